state_array_packer: RTL

//   Inverse of the 128-bit-to-4x4 state splitter: collects an AES state one column per beat
//   (row1..row4 bytes) over a valid/ready interface and packs it into one 128-bit flat word.

---
 rtl/state_array_packer.sv | 102 ++++++++++
 1 files changed

// File: rtl/state_array_packer.sv
// Purpose: gathers an AES state one column per beat and packs it column-major into a flat 128-bit word.
// Latency: out_valid rises the cycle after the last column is accepted; no same-cycle bypass.
// Backpressure: in_ready drops while a packed state is held; the state stays until out_ready, then collection resumes.
module state_array_packer #(
  parameter int DATA_W   = 8,
  parameter int NUM_COLS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_row1,
  input  logic [DATA_W-1:0]             in_row2,
  input  logic [DATA_W-1:0]             in_row3,
  input  logic [DATA_W-1:0]             in_row4,
  output logic [2:0]                    col_idx,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [4*DATA_W*NUM_COLS:1]    output_array
);

  localparam int COL_W = 4 * DATA_W;
  localparam int OUT_W = COL_W * NUM_COLS;
  localparam int IDX_W = $clog2(NUM_COLS);
  localparam logic [2:0] LAST_COL = 3'(NUM_COLS - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       col_idx_q, col_idx_d;
  logic [COL_W-1:0] col_q [NUM_COLS];
  logic [COL_W-1:0] col_d [NUM_COLS];
  logic [COL_W-1:0] in_col;

  // Row 1 is the top byte of a column, so it lands in the most significant position.
  assign in_col = {in_row1, in_row2, in_row3, in_row4};

  // Next-state: clear wins over everything, otherwise collect columns or wait for the output handshake.
  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    col_d     = col_q;
    if (clear) begin
      state_d   = COLLECT;
      col_idx_d = '0;
      for (int c = 0; c < NUM_COLS; c++) begin
        col_d[c] = '0;
      end
    end else begin
      case (state_q)
        COLLECT: begin
          if (in_valid) begin
            col_d[col_idx_q[IDX_W-1:0]] = in_col;
            if (col_idx_q == LAST_COL) begin
              col_idx_d = '0;
              state_d   = FULL;
            end else begin
              col_idx_d = col_idx_q + 3'd1;
            end
          end
        end
        FULL: begin
          // The handshake cycle itself never accepts a column.
          if (out_ready) begin
            state_d = COLLECT;
          end
        end
      endcase
    end
  end

  // State, column counter and column storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      col_idx_q <= '0;
      for (int c = 0; c < NUM_COLS; c++) begin
        col_q[c] <= '0;
      end
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      for (int c = 0; c < NUM_COLS; c++) begin
        col_q[c] <= col_d[c];
      end
    end
  end

  // Column 0 occupies the top of the flat word, the last column the bottom.
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_pack
    assign output_array[OUT_W - COL_W*c -: COL_W] = col_q[c];
  end

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == FULL);
  assign col_idx   = col_idx_q;

endmodule
